ranc_grid_run_ctrl: RTL
=======================

Name: ranc_grid_run_ctrl

Overview:
Host-facing controller that configures and sequences a RANC network grid (core + output bus).
- Assembles 368-bit core parameter rows and 2-bit neuron instructions from a 32-bit configuration stream, and drives the grid's param/neuron_inst write ports.
- Runs a programmed number of timesteps. Each timestep: wait for the input spike buffer to drain, let the mesh settle, pulse tick.
- Sits between the SoC CSR/DMA layer and the grid; watches the grid's error flags.

Parameters:
PARAM_WIDTH, 368, width of one core parameter row
WORD_WIDTH, 32, configuration beat width
NUM_NEURONS, 256, rows per core; address width = $clog2(NUM_NEURONS)
SETTLE_CYCLES, 16, idle cycles between buffer drain and tick (mesh propagation)
TICK_GAP, 4, cycles after tick before the next drain check
TICK_CNT_W, 16, width of timestep counters

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  configuration beat valid
cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready
cfg_sel  in  1  0 = param beat, 1 = neuron instruction
cfg_addr  in  8  neuron row address, sampled on the final param beat / on an instruction beat
cfg_data  in  32  beat payload
start  in  1  one-cycle run request
num_ticks  in  16  timesteps to run, sampled on accepted start
err_clear  in  1  clears the ERROR state
input_buffer_empty  in  1  grid input FIFO empty
token_controller_error  in  1  grid error
scheduler_error  in  1  grid error
tick  out  1  one-cycle timestep pulse to grid
param_wen  out  1  param row write strobe
param_address  out  8  param row address
param_data_in  out  368  param row data
neuron_inst_wen  out  1  instruction write strobe
neuron_inst_address  out  8  instruction address
neuron_inst_data_in  out  2  instruction data
busy  out  1  high in any state except IDLE, DONE and ERROR
done  out  1  one-cycle pulse at end of run
error  out  1  high in ERROR
ticks_done  out  16  timesteps issued in the current or last run

Behaviour:
Reset:
- All outputs 0; FSM = IDLE; beat counter = 0; param_data_in = 0.

Configuration (ready only in IDLE):
- cfg_ready = 1 in IDLE, 0 elsewhere.
- Param beats: beat k (0..11) loads param_data_in[32k+31:32k]. On beat 11 only cfg_data[15:0] is used; bits 31:16 are ignored.
- After beat 11 is accepted: param_address = cfg_addr captured on that beat; param_wen pulses exactly 1 cycle in the next cycle. Beat counter wraps to 0.
- param_data_in and param_address stay stable until the next row completes.
- Instruction beat: neuron_inst_address = cfg_addr and neuron_inst_data_in = cfg_data[1:0]. neuron_inst_wen pulses 1 cycle in the next cycle.
- An instruction beat does not disturb a partially assembled param row.
- Accepted start clears the param beat counter; any partial row is discarded.

Run FSM:
- IDLE: start latches num_ticks and clears ticks_done.
  - num_ticks = 0 → DONE immediately, with no tick.
  - Otherwise → DRAIN.
- DRAIN: wait until input_buffer_empty = 1 → SETTLE, with the counter loaded to SETTLE_CYCLES-1.
- SETTLE: decrement the counter. If input_buffer_empty drops to 0, return to DRAIN. At 0 → TICK.
- TICK: tick = 1 for exactly this cycle; ticks_done increments → GAP.
- GAP: count TICK_GAP cycles, then:
  - ticks_done == latched num_ticks → DONE
  - otherwise → DRAIN
- DONE: done = 1 for one cycle → IDLE.
- ERROR: entered from any state except IDLE on token_controller_error | scheduler_error.
  - Error has priority over every other transition; a pending tick is suppressed.
  - Stays in ERROR until err_clear → IDLE.
  - ticks_done is frozen in ERROR.
- start while not in IDLE is ignored.
- start and cfg_valid in the same IDLE cycle: both are accepted.
- Errors are ignored in IDLE.
- Asynchronous reset mid-run returns to IDLE with tick = 0 in the same cycle. No further write strobes are issued.
- ticks_done wraps modulo 2^16 (it cannot exceed num_ticks).

Test Plan:
1. Reset then 12 param beats with data = beat index and cfg_addr = 0x2A on beat 11 → one param_wen pulse; param_address = 0x2A; param_data_in[31:0] = 0, [351:320] = 10, [367:352] = 0x000B.
2. 5 param beats, then an instruction beat (addr 0x07, data 2'b10), then 7 more param beats → neuron_inst_wen once with addr 0x07, data 2; then param_wen once with the row intact.
3. start with num_ticks = 3 and input_buffer_empty held at 1 → exactly 3 tick pulses spaced SETTLE_CYCLES+TICK_GAP+1 = 21 cycles apart; done pulse; ticks_done = 3; cfg_ready = 0 throughout.
4. During SETTLE, input_buffer_empty drops for 2 cycles → FSM returns to DRAIN, and the settle count restarts at 16 after it returns high.
5. scheduler_error asserted during run at tick 2 → error = 1, no further ticks, ticks_done = 2; err_clear → IDLE; a new start with num_ticks = 0 → done pulse and no tick.

Source files
------------

// File: rtl/ranc_grid_run_ctrl.sv
// rtl/ranc_grid_run_ctrl.sv - Configuration assembler and timestep sequencer for a RANC grid
//
// Purpose:
//   Builds core parameter rows (PARAM_WIDTH bits) and 2-bit neuron instructions
//   from a WORD_WIDTH configuration stream and drives the grid write ports.
//   Runs a programmed number of timesteps. Each timestep waits for the input
//   spike buffer to drain, lets the mesh settle, then pulses tick. Grid error
//   flags park the controller in ERROR until cleared.
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   cfg_valid/cfg_ready               configuration beat handshake (ready in IDLE only)
//   cfg_sel, cfg_addr, cfg_data       beat type (0 param, 1 instruction), row address, payload
//   start, num_ticks                  run request and timestep count
//   err_clear                         leaves ERROR
//   input_buffer_empty                grid input FIFO empty
//   token_controller_error,
//   scheduler_error                   grid error flags
//   tick                              one-cycle timestep pulse
//   param_wen/address/data_in         parameter row write port
//   neuron_inst_wen/address/data_in   neuron instruction write port
//   busy, done, error, ticks_done     run status

module ranc_grid_run_ctrl #(
    parameter int PARAM_WIDTH   = 368,
    parameter int WORD_WIDTH    = 32,
    parameter int NUM_NEURONS   = 256,
    parameter int SETTLE_CYCLES = 16,
    parameter int TICK_GAP      = 4,
    parameter int TICK_CNT_W    = 16,
    localparam int ADDR_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_sel,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [WORD_WIDTH-1:0]  cfg_data,
    input  logic                   start,
    input  logic [TICK_CNT_W-1:0]  num_ticks,
    input  logic                   err_clear,
    input  logic                   input_buffer_empty,
    input  logic                   token_controller_error,
    input  logic                   scheduler_error,
    output logic                   tick,
    output logic                   param_wen,
    output logic [ADDR_W-1:0]      param_address,
    output logic [PARAM_WIDTH-1:0] param_data_in,
    output logic                   neuron_inst_wen,
    output logic [ADDR_W-1:0]      neuron_inst_address,
    output logic [1:0]             neuron_inst_data_in,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [TICK_CNT_W-1:0]  ticks_done
);

    localparam int NUM_BEATS = (PARAM_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int ASM_W     = (NUM_BEATS - 1) * WORD_WIDTH;
    localparam int LAST_W    = PARAM_WIDTH - ASM_W;
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam int CNT_W     = $clog2(SETTLE_CYCLES + TICK_GAP) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    // One-hot so every status output is a direct decode of state flops.
    typedef enum logic [6:0] {
        S_IDLE   = 7'b000_0001,
        S_DRAIN  = 7'b000_0010,
        S_SETTLE = 7'b000_0100,
        S_TICK   = 7'b000_1000,
        S_GAP    = 7'b001_0000,
        S_DONE   = 7'b010_0000,
        S_ERROR  = 7'b100_0000
    } state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [TICK_CNT_W-1:0]   r_num_ticks;
    logic [TICK_CNT_W-1:0]   r_ticks_done;

    logic [BEAT_W-1:0]       r_beat;
    logic [ASM_W-1:0]        r_asm;
    logic [PARAM_WIDTH-1:0]  r_param_data;
    logic [ADDR_W-1:0]       r_param_addr;
    logic                    r_param_wen;
    logic [ADDR_W-1:0]       r_inst_addr;
    logic [1:0]              r_inst_data;
    logic                    r_inst_wen;

    logic w_idle;
    logic w_cfg_accept;
    logic w_grid_err;

    assign w_idle       = (r_state == S_IDLE);
    // Ready is held low while reset is asserted so every output reads 0 in reset.
    assign cfg_ready    = w_idle & reset_n;
    assign w_cfg_accept = cfg_valid & cfg_ready;
    assign w_grid_err   = token_controller_error | scheduler_error;

    // Configuration path. Beats 0..NUM_BEATS-2 collect into a shadow buffer so the
    // visible row only changes when a complete row is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat       <= '0;
            r_asm        <= '0;
            r_param_data <= '0;
            r_param_addr <= '0;
            r_param_wen  <= 1'b0;
            r_inst_addr  <= '0;
            r_inst_data  <= '0;
            r_inst_wen   <= 1'b0;
        end else begin
            r_param_wen <= 1'b0;
            r_inst_wen  <= 1'b0;
            if (w_cfg_accept && !cfg_sel) begin
                if (r_beat == LAST_BEAT) begin
                    r_param_data <= {cfg_data[LAST_W-1:0], r_asm};
                    r_param_addr <= cfg_addr;
                    r_param_wen  <= 1'b1;
                    r_beat       <= '0;
                end else begin
                    for (int k = 0; k < NUM_BEATS - 1; k++) begin
                        if (r_beat == BEAT_W'(k)) begin
                            r_asm[k*WORD_WIDTH +: WORD_WIDTH] <= cfg_data;
                        end
                    end
                    r_beat <= r_beat + 1'b1;
                end
            end
            if (w_cfg_accept && cfg_sel) begin
                r_inst_addr <= cfg_addr;
                r_inst_data <= cfg_data[1:0];
                r_inst_wen  <= 1'b1;
            end
            // A run start discards any partially assembled row.
            if (w_idle && start) begin
                r_beat <= '0;
            end
        end
    end

    // Run sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_num_ticks  <= '0;
            r_ticks_done <= '0;
        end else if (w_grid_err && r_state != S_IDLE && r_state != S_ERROR) begin
            r_state <= S_ERROR;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_ticks  <= num_ticks;
                        r_ticks_done <= '0;
                        r_state      <= (num_ticks == '0) ? S_DONE : S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (input_buffer_empty) begin
                        r_cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (!input_buffer_empty) begin
                        r_state <= S_DRAIN;
                    end else if (r_cnt == '0) begin
                        // Counted on entry so the count matches the pulse even if
                        // an error lands during the tick cycle itself.
                        r_ticks_done <= r_ticks_done + 1'b1;
                        r_state      <= S_TICK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_TICK: begin
                    // The tick cycle is the first of the TICK_GAP cycles before
                    // the next drain check.
                    r_cnt   <= CNT_W'(TICK_GAP - 2);
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= (r_ticks_done == r_num_ticks) ? S_DONE : S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_ERROR: begin
                    if (err_clear) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tick                = (r_state == S_TICK);
    assign done                = (r_state == S_DONE);
    assign error               = (r_state == S_ERROR);
    assign busy                = (r_state == S_DRAIN) || (r_state == S_SETTLE) ||
                                 (r_state == S_TICK)  || (r_state == S_GAP);
    assign ticks_done          = r_ticks_done;
    assign param_wen           = r_param_wen;
    assign param_address       = r_param_addr;
    assign param_data_in       = r_param_data;
    assign neuron_inst_wen     = r_inst_wen;
    assign neuron_inst_address = r_inst_addr;
    assign neuron_inst_data_in = r_inst_data;

endmodule
